// File: rtl/msg_assembler.sv
// Reassembles a most-significant-first stream of KEY_SIZE-bit chunks into one
// MSG_SIZE-bit message, presented with a valid/ack handshake.
module msg_assembler #(
  parameter int KEY_SIZE = 16,
  parameter int MSG_SIZE = 240,
  localparam int N_CHUNKS = MSG_SIZE / KEY_SIZE,
  localparam int CNT_W = $clog2(N_CHUNKS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [KEY_SIZE-1:0] in_chunk,
  output logic                in_ready,
  output logic [MSG_SIZE-1:0] msg_out,
  output logic                msg_valid,
  input  logic                msg_ack,
  output logic [CNT_W-1:0]    chunk_count,
  output logic                overrun
);

  if ((MSG_SIZE % KEY_SIZE) != 0) begin : g_size_check
    $error("msg_assembler: MSG_SIZE must be a multiple of KEY_SIZE");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   last_chunk;
  logic   arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs depend on the registered state only
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    msg_valid  = 1'b0;
    accept     = 1'b0;
    last_chunk = 1'b0;
    arm        = 1'b0;
    case (state)
      IDLE: begin
        arm = start;
        if (start) state_next = COLLECT;
      end
      COLLECT: begin
        in_ready   = 1'b1;
        accept     = in_valid;
        last_chunk = in_valid && (chunk_count == CNT_W'(N_CHUNKS - 1));
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        msg_valid = 1'b1;
        if (msg_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register written via a shift so KEY_SIZE == MSG_SIZE stays legal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_out     <= '0;
      chunk_count <= '0;
    end else if (arm) begin
      msg_out     <= '0;
      chunk_count <= '0;
    end else if (accept) begin
      msg_out     <= (msg_out << KEY_SIZE) | MSG_SIZE'(in_chunk);
      chunk_count <= chunk_count + CNT_W'(1);
    end
  end

  // A clearing start wins over a same-edge stray chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (arm) begin
      overrun <= 1'b0;
    end else if (in_valid && (state != COLLECT)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_msg_assembler.sv
// Self-checking bench for msg_assembler: vector table for single-cycle rules,
// scoreboarded full-message runs for the multi-cycle behaviour.
module tb_msg_assembler;

  localparam int KEY_SIZE = 16;
  localparam int MSG_SIZE = 240;
  localparam int N_CHUNKS = 15;
  localparam int CNT_W    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic [KEY_SIZE-1:0] in_chunk = '0;
  logic                msg_ack = 1'b0;
  logic                in_ready;
  logic [MSG_SIZE-1:0] msg_out;
  logic                msg_valid;
  logic [CNT_W-1:0]    chunk_count;
  logic                overrun;

  int compared = 0;
  int mismatched = 0;
  logic [MSG_SIZE-1:0] exp_q[$];
  logic [MSG_SIZE-1:0] last_exp;

  typedef struct {
    logic        start;
    logic        in_valid;
    logic [15:0] chunk;
    logic        ack;
    logic        exp_ready;
    logic        exp_valid;
    int          exp_cnt;
    logic        exp_ov;
    logic [31:0] exp_low;
  } vec_t;

  vec_t vecs[8];

  msg_assembler #(.KEY_SIZE(KEY_SIZE), .MSG_SIZE(MSG_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_chunk(in_chunk), .in_ready(in_ready), .msg_out(msg_out),
    .msg_valid(msg_valid), .msg_ack(msg_ack), .chunk_count(chunk_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [MSG_SIZE-1:0] actual,
                             input logic [MSG_SIZE-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic s, input logic v, input logic [15:0] c,
                               input logic a);
    start = s;
    in_valid = v;
    in_chunk = c;
    msg_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    start = 1'b0;
    in_valid = 1'b0;
    msg_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_msg"}, msg_out, '0);
    checkValue({tag, "_count"}, int'(chunk_count), 0);
    checkValue({tag, "_ready"}, int'(in_ready), 0);
    checkValue({tag, "_valid"}, int'(msg_valid), 0);
    checkValue({tag, "_overrun"}, int'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Start a message and feed base+0 .. base+14; edges counts E0 inclusive
  task automatic runMessage(input string tag, input logic [15:0] base, input bit gapped,
                            input bit ack_on_last, input int start_at,
                            input int exp_latency);
    logic [MSG_SIZE-1:0] exp_msg;
    logic [15:0]         chunk;
    int                  edges;
    int                  accepted;
    int                  guard;
    bit                  v;
    exp_msg = '0;
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    edges = 1;
    accepted = 0;
    checkValue({tag, "_ready"}, int'(in_ready), 1);
    while (accepted < N_CHUNKS && edges < 200) begin
      v = gapped ? edges[0] : 1'b1;
      chunk = v ? base + 16'(accepted) : 16'hDEAD;
      applyStimulus((v && accepted == start_at) ? 1'b1 : 1'b0, v, chunk,
                    (ack_on_last && v && accepted == N_CHUNKS - 1) ? 1'b1 : 1'b0);
      edges++;
      if (v) begin
        exp_msg = {exp_msg[MSG_SIZE-KEY_SIZE-1:0], chunk};
        accepted++;
      end
      checkValue({tag, "_count"}, int'(chunk_count), accepted);
    end
    start = 1'b0;
    in_valid = 1'b0;
    msg_ack = 1'b0;
    exp_q.push_back(exp_msg);
    last_exp = exp_msg;
    guard = 0;
    while (!msg_valid && guard < 50) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      edges++;
      guard++;
    end
    if (!msg_valid) checkValue({tag, "_timeout"}, 0, 1);
    checkValue({tag, "_latency"}, edges, exp_latency);
    checkValue({tag, "_ready_done"}, int'(in_ready), 0);
    if (exp_q.size() == 0) checkValue({tag, "_queue"}, 0, 1);
    else checkOutput({tag, "_msg"}, msg_out, exp_q.pop_front());
    checkValue({tag, "_final_count"}, int'(chunk_count), N_CHUNKS);
  endtask

  initial begin
    $display("[TB] msg_assembler test starting");
    #2;
    checkOutput("por_msg", msg_out, '0);
    checkValue("por_valid", int'(msg_valid), 0);
    checkValue("por_ready", int'(in_ready), 0);
    checkValue("por_count", int'(chunk_count), 0);
    checkValue("por_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // start, in_valid, chunk, ack | ready, valid, count, overrun, msg_out[31:0]
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 1, 1'b0, 32'h0000_1234};
    vecs[5] = '{1'b0, 1'b0, 16'h9999, 1'b0, 1'b1, 1'b0, 1, 1'b0, 32'h0000_1234};
    vecs[6] = '{1'b1, 1'b1, 16'h5678, 1'b0, 1'b1, 1'b0, 2, 1'b0, 32'h1234_5678};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2, 1'b0, 32'h1234_5678};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].start, vecs[i].in_valid, vecs[i].chunk, vecs[i].ack);
      checkValue($sformatf("vec%0d_ready", i), int'(in_ready), int'(vecs[i].exp_ready));
      checkValue($sformatf("vec%0d_valid", i), int'(msg_valid), int'(vecs[i].exp_valid));
      checkValue($sformatf("vec%0d_count", i), int'(chunk_count), vecs[i].exp_cnt);
      checkValue($sformatf("vec%0d_overrun", i), int'(overrun), int'(vecs[i].exp_ov));
      checkOutput($sformatf("vec%0d_low", i), {208'h0, msg_out[31:0]},
                  {208'h0, vecs[i].exp_low});
    end
    doReset("rst_table");

    runMessage("b2b", 16'h0001, 1'b0, 1'b1, -1, 16);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkValue("ack_same_edge_valid", int'(msg_valid), 1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkValue("b2b_ack_valid", int'(msg_valid), 0);
    checkOutput("b2b_literal", msg_out,
      240'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F);

    runMessage("gap", 16'hA000, 1'b1, 1'b0, -1, 30);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      checkValue($sformatf("hold%0d_valid", i), int'(msg_valid), 1);
      checkOutput($sformatf("hold%0d_msg", i), msg_out, last_exp);
    end
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0);
    checkValue("ovr_set", int'(overrun), 1);
    checkOutput("ovr_msg", msg_out, last_exp);
    checkValue("ovr_count", int'(chunk_count), N_CHUNKS);
    checkValue("ovr_valid", int'(msg_valid), 1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkValue("ack_valid", int'(msg_valid), 0);
    checkValue("ack_ready", int'(in_ready), 0);
    checkValue("ack_overrun_sticky", int'(overrun), 1);
    checkOutput("idle_msg_kept", msg_out, last_exp);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkValue("restart_overrun", int'(overrun), 0);
    checkValue("restart_ready", int'(in_ready), 1);
    checkOutput("restart_msg", msg_out, '0);
    checkValue("restart_count", int'(chunk_count), 0);

    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 16'h0C00 + 16'(i), 1'b0);
    checkValue("partial_count", int'(chunk_count), 7);
    doReset("rst_mid");

    runMessage("fresh", 16'h0100, 1'b0, 1'b0, 3, 16);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkValue("fresh_ack_valid", int'(msg_valid), 0);
    msg_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/msg_assembler.md
# msg_assembler

Receive-side counterpart of the key-width message serializer: accepts a stream of `KEY_SIZE`-bit chunks, most-significant chunk first, and reassembles them into one `MSG_SIZE`-bit message. It sits after the XOR/key stage in the one-time-pad datapath. It presents the completed message with a valid/ack handshake and flags chunks that arrive when it is not collecting.

## Interface
- `KEY_SIZE`, default 16: chunk width in bits.
- `MSG_SIZE`, default 240: message width in bits. Must be an integer multiple of `KEY_SIZE`. `N_CHUNKS = MSG_SIZE/KEY_SIZE` (15 at defaults).
- `CNT_W`, derived as `$clog2(N_CHUNKS+1)`, not overridable: counter width (4 at defaults).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  arms a new collection; honored only in IDLE.
- `in_valid`  in  1  chunk present on `in_chunk`.
- `in_chunk`  in  KEY_SIZE  chunk data.
- `in_ready`  out  1  block accepts a chunk this cycle.
- `msg_out`  out  MSG_SIZE  assembled message.
- `msg_valid`  out  1  `msg_out` complete and stable.
- `msg_ack`  in  1  consumer has taken `msg_out`.
- `chunk_count`  out  CNT_W  chunks accepted in the current message.
- `overrun`  out  1  sticky: `in_valid` seen while not collecting.

## Operation
- FSM states are IDLE, COLLECT and DONE. The reset state is IDLE.
- **IDLE:**
  - `start` moves the FSM to COLLECT.
  - On that same edge, `msg_out`, `chunk_count` and `overrun` are cleared.
- **COLLECT:**
  - `in_ready`=1.
  - A chunk is accepted on any edge with `in_valid && in_ready`.
  - On acceptance, `msg_out <= {msg_out[MSG_SIZE-KEY_SIZE-1:0], in_chunk}` and `chunk_count` increments.
  - The first accepted chunk therefore ends in `msg_out[MSG_SIZE-1 -: KEY_SIZE]`.
  - On the edge that accepts chunk number `N_CHUNKS`, the FSM moves to DONE.
  - `start` is ignored in this state.
- **DONE:**
  - `msg_valid`=1 and `in_ready`=0.
  - `msg_out` and `chunk_count` (= `N_CHUNKS`) are frozen.
  - `msg_ack` moves the FSM to IDLE.
  - `msg_out` keeps its value in IDLE until the next `start`.
- **Overrun:** `in_valid`=1 in IDLE or DONE sets `overrun`. The chunk is dropped and no other state changes. `overrun` clears only on an accepted `start` or on reset.
- **Output decoding:** `in_ready` and `msg_valid` are decoded from registered state only, never combinationally from inputs. All other outputs are registers.
- **Reset:** `rst_n` low at any time, including mid-COLLECT, asynchronously forces:
  - IDLE;
  - `msg_out`=0, `chunk_count`=0;
  - `msg_valid`=0, `in_ready`=0, `overrun`=0.
  
  A partial message is discarded.
- **Parameter check:** if `MSG_SIZE % KEY_SIZE != 0`, elaboration fails (`$error` in an initial/generate check).

## Timing
- `start` sampled at edge E0 → `in_ready`=1 from the cycle after E0.
- With `in_valid` held high, chunks are accepted on edges E1…E15, one per cycle with no bubbles.
- `msg_valid` rises in the cycle after E15 (1-cycle latency from the last acceptance). `in_ready` falls in that same cycle.
- Minimum start-to-`msg_valid` time is `N_CHUNKS`+1 cycles.
- **Producer gaps:** a low `in_valid` stalls collection with no timeout. `chunk_count` and `msg_out` hold.
- **Ack timing:**
  - `msg_ack` sampled high in DONE → `msg_valid`=0 the next cycle.
  - A new `start` is honored earliest one edge after that, since the FSM must be in IDLE.
  - `msg_ack` outside DONE is ignored.
- **Simultaneous events:**
  - `start` and `in_valid` on the same edge in IDLE: transition to COLLECT, chunk not accepted, `overrun` set then cleared by `start`. Clear has priority, so `overrun`=0.
  - Last-chunk acceptance and `msg_ack` on the same edge: `msg_ack` ignored, because the FSM was not yet in DONE.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-run → all outputs zero and FSM in IDLE within the reset assertion, not waiting for a clock edge.
- **Back-to-back:** `start`, then chunks 0x0001…0x000F with `in_valid` held high →
  - `msg_valid` high exactly 16 cycles after the `start` edge;
  - `msg_out`=240'h0001_0002_0003_…_000E_000F;
  - `chunk_count`=15.
- **Gapped input:** toggle `in_valid` every other cycle with chunks 0xA000+i → same ordering; `msg_valid` high 30 cycles after `start`; no acceptance on low-valid cycles.
- **Overrun:** hold `msg_valid` (no ack) and drive `in_valid` with 0xFFFF →
  - `overrun`=1 next cycle;
  - `msg_out` unchanged;
  - after ack and `start`, `overrun`=0.
- **Reset mid-collect:** accept 7 chunks, pull `rst_n` low for 1 cycle → `chunk_count`=0, `msg_out`=0, IDLE. A fresh 15-chunk run then produces a clean message with no leftover chunks.
- **Handshake rules:** `start` pulsed while in COLLECT after 3 chunks → ignored, count continues 4…15. Hold `msg_ack` low for 10 cycles in DONE → `msg_valid` and `msg_out` stable throughout. One-cycle `msg_ack` → `msg_valid`=0 next cycle.
